// File: rtl/servcle_ring_ctrl.sv
// servcle_ring_ctrl
//   Head/tail controller of the servcle token ring. It is the only token
//   source: it injects the token, takes it back from the last entry, and
//   re-injects it only while the sink FIFO can absorb a worst-case burst.
//   Ring data is collected into a first-word-fall-through FIFO that drains
//   through a valid/ready stream. A watchdog regenerates a lost token.
//
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_en           allow token (re)injection
//   i_data/i_valid ring data from the last entry
//   i_token        token returning from the last entry
//   o_token        token to the first entry, one-cycle pulse
//   o_data/o_valid stream output (FIFO head / FIFO not empty)
//   i_ready        stream ready
//   o_overflow     sticky: ring word dropped because the FIFO was full
//   o_err          sticky: token received while not circulating
//   o_lost_cnt     watchdog regenerations (wraps)
//   o_rounds       completed token rounds (wraps)
module servcle_ring_ctrl #(
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    input  logic          i_token,
    output logic          o_token,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_overflow,
    output logic          o_err,
    output logic [7:0]    o_lost_cnt,
    output logic [15:0]   o_rounds
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_HOLD,
        S_INJECT,
        S_CIRC
    } state_t;

    state_t r_state, w_state_next;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count_next;
    logic [WW-1:0] r_wd, w_wd_next;
    logic          r_overflow, r_err;
    logic [7:0]    r_lost_cnt;
    logic [15:0]   r_rounds;

    logic w_full, w_pop, w_push, w_room;
    logic w_round, w_lost, w_err;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = o_valid & i_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push  = i_valid & (~w_full | w_pop);

    // Room is judged on the occupancy after this cycle's push/pop.
    assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_room       = ((AW+1)'(DEPTH) - w_count_next) >= (AW+1)'(MAX_BURST);

    assign o_valid    = (r_count != '0);
    assign o_data     = r_mem[r_rd_ptr];
    assign o_token    = (r_state == S_INJECT);
    assign o_overflow = r_overflow;
    assign o_err      = r_err;
    assign o_lost_cnt = r_lost_cnt;
    assign o_rounds   = r_rounds;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_HOLD;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_wd_next    = r_wd;
        w_round      = 1'b0;
        w_lost       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_HOLD: begin
                w_err = i_token;
                if (i_en && w_room) w_state_next = S_INJECT;
            end
            S_INJECT: begin
                w_err        = i_token;
                w_wd_next    = '0;
                w_state_next = S_CIRC;
            end
            S_CIRC: begin
                // A returning token beats a simultaneous watchdog expiry.
                if (i_token) begin
                    w_round      = 1'b1;
                    w_state_next = (i_en && w_room) ? S_INJECT : S_HOLD;
                end else if (i_valid) begin
                    w_wd_next = '0;
                end else if (r_wd == WW'(TIMEOUT - 1)) begin
                    w_lost       = 1'b1;
                    w_state_next = S_HOLD;
                end else begin
                    w_wd_next = r_wd + 1'b1;
                end
            end
            default: w_state_next = S_HOLD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wd       <= '0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
            r_lost_cnt <= '0;
            r_rounds   <= '0;
        end else begin
            r_count <= w_count_next;
            r_wd    <= w_wd_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_valid && !w_push) r_overflow <= 1'b1;
            if (w_err)   r_err      <= 1'b1;
            if (w_lost)  r_lost_cnt <= r_lost_cnt + 1'b1;
            if (w_round) r_rounds   <= r_rounds + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: tb/tb_servcle_ring_ctrl.sv
module tb_servcle_ring_ctrl;

    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int MAX_BURST = 4;
    localparam int TIMEOUT   = 1024;

    logic          clk = 1'b0;
    logic          rst, en, valid, tok, ready;
    logic [DW-1:0] data;
    logic          o_token, o_valid, o_overflow, o_err;
    logic [DW-1:0] o_data;
    logic [7:0]    o_lost_cnt;
    logic [15:0]   o_rounds;

    servcle_ring_ctrl #(
        .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_valid(valid),
        .i_token(tok), .o_token(o_token), .o_data(o_data), .o_valid(o_valid),
        .i_ready(ready), .o_overflow(o_overflow), .o_err(o_err),
        .o_lost_cnt(o_lost_cnt), .o_rounds(o_rounds)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: token location flags, idle counter, FIFO as a queue.
    logic [DW-1:0] q[$];
    bit            m_tok;      // token being handed to the first entry this cycle
    bit            m_out;      // token travelling through the ring
    int            m_idle;
    bit            m_ovf, m_err;
    logic [7:0]    m_lost;
    logic [15:0]   m_rounds;

    task automatic model_step();
        bit pop, acc, room;
        if (rst) begin
            q.delete();
            m_tok = 0; m_out = 0; m_idle = 0; m_ovf = 0; m_err = 0;
            m_lost = '0; m_rounds = '0;
            return;
        end
        pop = (q.size() > 0) && ready;
        acc = valid && ((q.size() < DEPTH) || pop);
        if (valid && !acc) m_ovf = 1;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(data);
        room = (DEPTH - q.size()) >= MAX_BURST;
        if (m_tok) begin
            if (tok) m_err = 1;
            m_tok = 0; m_out = 1; m_idle = 0;
        end else if (m_out) begin
            if (tok) begin
                m_rounds++;
                m_out = 0;
                m_tok = en && room;
            end else if (valid) begin
                m_idle = 0;
            end else if (m_idle == TIMEOUT - 1) begin
                m_lost++;
                m_out = 0;
            end else begin
                m_idle++;
            end
        end else begin
            if (tok) m_err = 1;
            m_tok = en && room;
        end
    endtask

    task automatic check_outputs();
        chk("token", o_token, m_tok);
        chk("valid", o_valid, q.size() > 0);
        if (q.size() > 0) chk("data", o_data, q[0]);
        chk("overflow", o_overflow, m_ovf);
        chk("err", o_err, m_err);
        chk("lost", o_lost_cnt, m_lost);
        chk("rounds", o_rounds, m_rounds);
    endtask

    // Inputs are set at the negedge before calling; outputs compared at the next negedge.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        valid = 0; tok = 0; rst = 0;
    endtask

    task automatic do_reset();
        rst = 1; valid = 0; tok = 0;
        step(); step();
        rst = 0;
    endtask

    task automatic wait_tok();
        int n = 0;
        while (!m_tok && n < 3000) begin
            idle_inputs();
            step();
            n++;
        end
        chk("wait_tok", o_token, 1);
    endtask

    task automatic ring_round(input int nwords, input logic [DW-1:0] base);
        wait_tok();
        for (int i = 0; i < nwords; i++) begin
            valid = 1; tok = 0; data = base + DW'(i);
            step();
        end
        valid = 0; tok = 1;
        step();
        tok = 0;
    endtask

    initial begin
        int ret_cnt, burst_left;
        rst = 1; en = 1; valid = 0; tok = 0; ready = 1; data = '0;
        @(negedge clk);

        // T1: first injection one cycle after release, loop back after 5 cycles
        do_reset();
        chk("t1_rst_token", o_token, 0);
        chk("t1_rst_valid", o_valid, 0);
        chk("t1_rst_rounds", o_rounds, 0);
        step();
        chk("t1_pulse", o_token, 1);
        step();
        chk("t1_pulse_width", o_token, 0);
        for (int r = 1; r <= 3; r++) begin
            repeat (4) step();
            tok = 1;
            step();
            tok = 0;
            chk("t1_reinject", o_token, 1);
            chk("t1_rounds", o_rounds, r);
            step();
        end

        // T2: four-word burst in order, then re-injection
        do_reset();
        ring_round(4, 8'hA1);
        chk("t2_retoken", o_token, 1);
        chk("t2_ovf", o_overflow, 0);
        repeat (4) step();

        // T3: back-pressure holds the token once free space drops below a burst
        do_reset();
        ready = 0;
        for (int b = 0; b < 3; b++) ring_round(4, DW'(8'h10 * (b + 1)));
        chk("t3_inject_at12", o_token, 1);
        ring_round(4, 8'h40);
        chk("t3_hold_at16", o_token, 0);
        repeat (5) step();
        ready = 1;
        repeat (4) step();
        ready = 0;
        chk("t3_release_at12", o_token, 1);
        repeat (3) step();
        ready = 1;
        repeat (20) step();

        // T4: lost token regenerated; periodic ring data keeps the watchdog quiet
        do_reset();
        wait_tok();
        repeat (TIMEOUT + 2) step();
        chk("t4_lost", o_lost_cnt, 1);
        chk("t4_regen", o_token, 1);
        for (int i = 0; i < 2600; i++) begin
            valid = (i % 500 == 0); data = 8'h77; tok = 0;
            step();
        end
        chk("t4_no_loss", o_lost_cnt, 1);

        // T5: overflow on full FIFO, and a full FIFO with simultaneous pop
        en = 0; ready = 0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            valid = 1; data = DW'(i);
            step();
        end
        data = 8'h55;
        step();
        valid = 0;
        chk("t5_ovf_set", o_overflow, 1);
        step();
        chk("t5_ovf_sticky", o_overflow, 1);
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            valid = 1; data = DW'(8'h80 + i);
            step();
        end
        ready = 1; data = 8'h55;
        step();
        valid = 0;
        chk("t5_no_ovf", o_overflow, 0);
        repeat (DEPTH + 2) step();

        // T6: stray token in HOLD, then reset in the middle of a burst
        en = 0;
        do_reset();
        tok = 1;
        step();
        tok = 0;
        chk("t6_err", o_err, 1);
        chk("t6_no_token", o_token, 0);
        en = 1; ready = 0;
        wait_tok();
        for (int i = 0; i < 3; i++) begin
            valid = 1; data = DW'(8'hC0 + i);
            step();
        end
        valid = 0; rst = 1;
        step();
        rst = 0;
        chk("t6_rst_valid", o_valid, 0);
        chk("t6_rst_err", o_err, 0);
        step();
        chk("t6_new_token", o_token, 1);
        repeat (6) step();
        ready = 1;

        // Randomized well-behaved ring: entries burst up to MAX_BURST, then return the token
        do_reset();
        ret_cnt = -1; burst_left = 0;
        for (int i = 0; i < 1500; i++) begin
            idle_inputs();
            en = 1;
            ready = ($urandom % 4) != 0;
            if (ret_cnt > 0) begin
                ret_cnt--;
                if (burst_left > 0 && ($urandom % 2) == 1) begin
                    valid = 1; data = DW'($urandom); burst_left--;
                end
            end else if (ret_cnt == 0) begin
                tok = 1; ret_cnt = -1;
            end
            if (m_tok) begin
                ret_cnt = $urandom_range(1, 10);
                burst_left = $urandom_range(0, MAX_BURST);
            end
            step();
        end
        chk("rand_ring_ovf", o_overflow, 0);

        // Unconstrained random traffic, stray tokens, enable toggling, rare resets
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom % 400) == 0;
            en    = ($urandom % 8) != 0;
            valid = ($urandom % 2) == 1;
            data  = DW'($urandom);
            ready = ($urandom % 3) != 0;
            tok   = ($urandom % 12) == 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
